// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Decode-stage producer table (Tnew countdown + stage life) that
//            drives the pipeline stall and the D-stage forwarding selects.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int NREG = 32,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      D_A1,
  input  logic [4:0]      D_A2,
  input  logic            Use_A1_D,
  input  logic            Use_A2_D,
  input  logic [1:0]      Tuse_A1_D,
  input  logic [1:0]      Tuse_A2_D,
  input  logic [4:0]      D_WR,
  input  logic            RegWrite_D,
  input  logic [2:0]      Tnew_D,
  output logic            stall,
  output logic [1:0]      Fwd_A1_D,
  output logic [1:0]      Fwd_A2_D,
  output logic [CNTW-1:0] stall_cnt
);

  localparam logic [1:0] c_LIFE_E = 2'd3;

  logic [2:0]      r_cnt  [NREG];
  logic [1:0]      r_life [NREG];
  logic [CNTW-1:0] r_stall_cnt;

  logic w_h1;
  logic w_h2;
  logic w_issue;
  logic [2:0] w_tnew_e;

  // life 3/2/1 (E/M/W) maps onto select 1/2/3; register 0 and idle entries read the GRF
  function automatic logic [1:0] fwd_sel(input logic [4:0] a, input logic [1:0] life);
    if (a == 5'd0 || life == 2'd0) return 2'd0;
    return 2'(3'd4 - {1'b0, life});
  endfunction

  always_comb begin
    w_h1 = Use_A1_D && (D_A1 != 5'd0) && (r_life[D_A1] != 2'd0)
           && (r_cnt[D_A1] > {1'b0, Tuse_A1_D});
    w_h2 = Use_A2_D && (D_A2 != 5'd0) && (r_life[D_A2] != 2'd0)
           && (r_cnt[D_A2] > {1'b0, Tuse_A2_D});
  end

  assign stall     = w_h1 | w_h2;
  assign Fwd_A1_D  = fwd_sel(D_A1, r_life[D_A1]);
  assign Fwd_A2_D  = fwd_sel(D_A2, r_life[D_A2]);
  assign stall_cnt = r_stall_cnt;

  assign w_issue  = !stall && RegWrite_D && (D_WR != 5'd0);
  assign w_tnew_e = (Tnew_D >= 3'd1) ? (Tnew_D - 3'd1) : 3'd0;

  // The issued entry replaces any older producer so the youngest one wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i]  <= 3'd0;
        r_life[i] <= 2'd0;
      end
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_issue && (D_WR == 5'(i))) begin
          r_cnt[i]  <= w_tnew_e;
          r_life[i] <= c_LIFE_E;
        end else begin
          r_cnt[i]  <= (r_cnt[i]  != 3'd0) ? (r_cnt[i]  - 3'd1) : 3'd0;
          r_life[i] <= (r_life[i] != 2'd0) ? (r_life[i] - 2'd1) : 2'd0;
        end
      end
      if (stall) r_stall_cnt <= r_stall_cnt + CNTW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Directed + random bench for hazard_scoreboard against an
//            age-based producer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  logic        clk;
  logic        reset;
  logic [4:0]  D_A1, D_A2, D_WR;
  logic        Use_A1_D, Use_A2_D, RegWrite_D;
  logic [1:0]  Tuse_A1_D, Tuse_A2_D;
  logic [2:0]  Tnew_D;
  logic        stall;
  logic [1:0]  Fwd_A1_D, Fwd_A2_D;
  logic [31:0] stall_cnt;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Model: per register, the cycle its youngest producer issued and its E-stage Tnew
  bit vld [32];
  int iss [32];
  int tn  [32];
  int cyc = 0;
  int m_scnt = 0;

  hazard_scoreboard #(.NREG(32), .CNTW(32)) dut (
    .clk(clk), .reset(reset),
    .D_A1(D_A1), .D_A2(D_A2),
    .Use_A1_D(Use_A1_D), .Use_A2_D(Use_A2_D),
    .Tuse_A1_D(Tuse_A1_D), .Tuse_A2_D(Tuse_A2_D),
    .D_WR(D_WR), .RegWrite_D(RegWrite_D), .Tnew_D(Tnew_D),
    .stall(stall), .Fwd_A1_D(Fwd_A1_D), .Fwd_A2_D(Fwd_A2_D),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_life(input int r);
    int age;
    if (!vld[r]) return 0;
    age = cyc - iss[r];
    return (age >= 3) ? 0 : 3 - age;
  endfunction

  function automatic int m_cnt(input int r);
    int t;
    if (!vld[r]) return 0;
    t = tn[r] - (cyc - iss[r]);
    return (t < 0) ? 0 : t;
  endfunction

  function automatic bit m_haz(input bit u, input int a, input int tuse);
    return u && a != 0 && m_life(a) != 0 && m_cnt(a) > tuse;
  endfunction

  function automatic bit m_stall();
    return m_haz(Use_A1_D, int'(D_A1), int'(Tuse_A1_D)) ||
           m_haz(Use_A2_D, int'(D_A2), int'(Tuse_A2_D));
  endfunction

  function automatic int m_fwd(input int a);
    if (a == 0 || m_life(a) == 0) return 0;
    return 4 - m_life(a);
  endfunction

  function automatic void m_clear();
    for (int r = 0; r < 32; r++) vld[r] = 1'b0;
    m_scnt = 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int a1, input int a2, input bit u1, input bit u2,
                        input int t1, input int t2, input int wr, input bit rw, input int tnew);
    D_A1 = 5'(a1); D_A2 = 5'(a2); Use_A1_D = u1; Use_A2_D = u2;
    Tuse_A1_D = 2'(t1); Tuse_A2_D = 2'(t2);
    D_WR = 5'(wr); RegWrite_D = rw; Tnew_D = 3'(tnew);
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Waits to the negedge and compares every output against the model
  task automatic sample(input string tag);
    @(negedge clk);
    check({tag, "_stall"}, 32'(stall),    32'(m_stall()));
    check({tag, "_fwd1"},  32'(Fwd_A1_D), 32'(m_fwd(int'(D_A1))));
    check({tag, "_fwd2"},  32'(Fwd_A2_D), 32'(m_fwd(int'(D_A2))));
    check({tag, "_scnt"},  stall_cnt,     32'(m_scnt));
  endtask

  task automatic tick();
    bit st;
    st = m_stall();
    if (st) m_scnt++;
    cyc++;
    if (!st && RegWrite_D && D_WR != 5'd0) begin
      vld[D_WR] = 1'b1;
      iss[D_WR] = cyc;
      tn[D_WR]  = (Tnew_D >= 3'd1) ? int'(Tnew_D) - 1 : 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_clear();
    idle();
    reset = 1'b0;
    #2;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_fwd1",  32'(Fwd_A1_D), 32'd0);
    check("rst_scnt",  stall_cnt, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // lw $8 then dependent add with Tuse=1
    set_in(0, 0, 0, 0, 0, 0, 8, 1, 3); sample("lw8"); tick();
    set_in(8, 0, 1, 0, 1, 0, 10, 1, 1); sample("add_c1");
    check("add_c1_stall_k", 32'(stall), 32'd1); tick();
    sample("add_c2");
    check("add_c2_stall_k", 32'(stall), 32'd0);
    check("add_c2_fwd_k", 32'(Fwd_A1_D), 32'd2); tick();
    idle(); sample("drain0");
    check("scnt_one_k", stall_cnt, 32'd1); tick();
    for (int k = 0; k < 3; k++) begin sample("drain"); tick(); end

    // add $9 then beq with Tuse=0
    set_in(0, 0, 0, 0, 0, 0, 9, 1, 2); sample("add9"); tick();
    set_in(9, 0, 1, 0, 0, 0, 0, 0, 0); sample("beq_c1");
    check("beq_c1_stall_k", 32'(stall), 32'd1); tick();
    sample("beq_c2");
    check("beq_c2_stall_k", 32'(stall), 32'd0);
    check("beq_c2_fwd_k", 32'(Fwd_A1_D), 32'd2); tick();

    // Younger producer of $8 overrides the lw
    set_in(0, 0, 0, 0, 0, 0, 8, 1, 3); sample("lw8b"); tick();
    set_in(0, 0, 0, 0, 0, 0, 8, 1, 2); sample("ori8"); tick();
    set_in(8, 0, 1, 0, 2, 0, 0, 0, 0); sample("rd8");
    check("rd8_fwd_k", 32'(Fwd_A1_D), 32'd1);
    check("rd8_stall_k", 32'(stall), 32'd0); tick();

    // $0 never stalls or forwards
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 3); sample("wr0"); tick();
    set_in(0, 0, 1, 1, 0, 0, 0, 0, 0); sample("rd0");
    check("rd0_stall_k", 32'(stall), 32'd0);
    check("rd0_fwd2_k", 32'(Fwd_A2_D), 32'd0); tick();

    // $5 ages out over three edges
    set_in(0, 0, 0, 0, 0, 0, 5, 1, 3); sample("p5"); tick();
    idle();
    for (int k = 0; k < 3; k++) begin sample("age5"); tick(); end
    set_in(5, 5, 1, 1, 0, 0, 0, 0, 0); sample("rd5");
    check("rd5_fwd_k", 32'(Fwd_A1_D), 32'd0);
    check("rd5_stall_k", 32'(stall), 32'd0); tick();

    // Reset asserted during a stall
    set_in(0, 0, 0, 0, 0, 0, 12, 1, 3); sample("lw12"); tick();
    set_in(12, 0, 1, 0, 0, 0, 0, 0, 0); sample("st12");
    check("st12_stall_k", 32'(stall), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("async_stall", 32'(stall), 32'd0);
    check("async_scnt", stall_cnt, 32'd0);
    m_clear();
    #1 reset = 1'b1;
    tick();
    sample("post_rst");
    check("post_rst_stall_k", 32'(stall), 32'd0); tick();

    // Random traffic on a small register set to force frequent hazards
    for (int n = 0; n < 400; n++) begin
      int a1, a2;
      a1 = $urandom_range(0, 7);
      a2 = ($urandom_range(0, 3) == 0) ? a1 : $urandom_range(0, 7);
      set_in(a1, a2, 1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7));
      sample("rnd");
      if (n == 200) begin
        #1 reset = 1'b0;
        #1;
        check("rnd_rst_stall", 32'(stall), 32'd0);
        check("rnd_rst_scnt", stall_cnt, 32'd0);
        m_clear();
        #1 reset = 1'b1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
